// File: rtl/nios_sys_pio_pkg.sv
// Shared constants for the Nios input PIO: Avalon widths, the register map and edge-type selectors.
package nios_sys_pio_pkg;

  localparam int unsigned PIO_DATA_W = 32;
  localparam int unsigned PIO_ADDR_W = 2;

  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/nios_sys_pio_keypad_edge_if.sv
// Avalon-MM slave bundle between the Nios data master and the input PIO.
interface nios_sys_pio_keypad_edge_if;
  import nios_sys_pio_pkg::*;

  logic [PIO_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [PIO_DATA_W-1:0] writedata;
  logic [PIO_DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_sys_pio_debounce.sv
// One input channel: synchroniser chain, optional stability counter and the accepted (stable) level.
module nios_sys_pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stable <= 1'b0;
        else       stable <= sync;
      end
    end else begin : g_debounce
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // Accept the new level only after it has disagreed for DEBOUNCE_CYCLES consecutive clocks.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (sync == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          stable <= sync;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nios_sys_pio_keypad_edge.sv
// Altera-PIO compatible input port: per-channel sync/debounce, W1C edge capture, maskable level irq.
module nios_sys_pio_keypad_edge
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = EDGE_RISING
) (
  input  logic                         clk,
  input  logic                         reset,
  nios_sys_pio_keypad_edge_if.slave    bus,
  input  logic [WIDTH-1:0]             in_port,
  output logic                         irq
);

  logic [WIDTH-1:0]      stable;
  logic [WIDTH-1:0]      stable_d;
  logic [WIDTH-1:0]      edge_pulse;
  logic [WIDTH-1:0]      irqmask;
  logic [WIDTH-1:0]      edgecap;
  logic [WIDTH-1:0]      clr_bits;
  logic                  wr;
  logic [PIO_DATA_W-1:0] rd_next;
  logic                  unused_wdata;

  for (genvar ch = 0; ch < int'(WIDTH); ch++) begin : g_ch
    nios_sys_pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[ch]),
      .stable (stable[ch])
    );
  end

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign edge_pulse = stable & ~stable_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_pulse = ~stable & stable_d;
    end else begin : g_any
      assign edge_pulse = stable ^ stable_d;
    end
  endgenerate

  assign wr           = bus.chipselect & ~bus.write_n;
  assign clr_bits     = (wr && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    rd_next = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:          rd_next = '0;
    endcase
  end

  // A new edge in the same clock as its W1C wins, so no edge is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d     <= '0;
      edgecap      <= '0;
      irqmask      <= '0;
      bus.readdata <= '0;
    end else begin
      stable_d     <= stable;
      edgecap      <= (edgecap & ~clr_bits) | edge_pulse;
      bus.readdata <= rd_next;
      if (wr && bus.address == PIO_ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_sys_pio_keypad_edge.sv
// Bench for the input PIO: four configurations driven in lockstep and checked against a behavioural model.
module tb_nios_sys_pio_keypad_edge;

  localparam int NDUT = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  wire  [3:0]  irq_v;
  logic [31:0] rd_v [NDUT];

  int errors = 0;
  int checks = 0;

  nios_sys_pio_keypad_edge_if bus0 ();
  nios_sys_pio_keypad_edge_if bus1 ();
  nios_sys_pio_keypad_edge_if bus2 ();
  nios_sys_pio_keypad_edge_if bus3 ();

  assign bus0.address = address; assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n; assign bus0.writedata  = writedata;
  assign bus1.address = address; assign bus1.chipselect = chipselect;
  assign bus1.write_n = write_n; assign bus1.writedata  = writedata;
  assign bus2.address = address; assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n; assign bus2.writedata  = writedata;
  assign bus3.address = address; assign bus3.chipselect = chipselect;
  assign bus3.write_n = write_n; assign bus3.writedata  = writedata;
  assign rd_v[0] = bus0.readdata;
  assign rd_v[1] = bus1.readdata;
  assign rd_v[2] = bus2.readdata;
  assign rd_v[3] = bus3.readdata;

  // dut0 rising, dut1 rising + debounce 8, dut2 falling, dut3 any edge
  nios_sys_pio_keypad_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq_v[0]));
  nios_sys_pio_keypad_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq_v[1]));
  nios_sys_pio_keypad_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq_v[2]));
  nios_sys_pio_keypad_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .in_port(in_port), .irq(irq_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted level follows the input two clocks late, and with debounce only
  // once the last N samples all disagree with the current accepted level.
  logic [3:0]  m_stable   [NDUT];
  logic [3:0]  m_stable_d [NDUT];
  logic [3:0]  m_edgecap  [NDUT];
  logic [3:0]  m_mask     [NDUT];
  logic [31:0] m_rd       [NDUT];
  logic [3:0]  m_hist     [NDUT][16];

  function automatic int dbc_of(int k);
    return (k == 1) ? 8 : 0;
  endfunction

  function automatic int ety_of(int k);
    return (k == 2) ? 1 : ((k == 3) ? 2 : 0);
  endfunction

  function automatic logic m_irq(int k);
    return |(m_edgecap[k] & m_mask[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_stable[k] = '0; m_stable_d[k] = '0; m_edgecap[k] = '0; m_mask[k] = '0; m_rd[k] = '0;
      for (int j = 0; j < 16; j++) m_hist[k][j] = '0;
    end
  endtask

  task automatic model_step();
    logic       wr;
    logic       flip;
    logic [3:0] pulse, clr, nst;
    wr = chipselect & ~write_n;
    for (int k = 0; k < NDUT; k++) begin
      case (address)
        2'd0:    m_rd[k] = {28'd0, m_stable[k]};
        2'd2:    m_rd[k] = {28'd0, m_mask[k]};
        2'd3:    m_rd[k] = {28'd0, m_edgecap[k]};
        default: m_rd[k] = 32'd0;
      endcase
      case (ety_of(k))
        0:       pulse = m_stable[k] & ~m_stable_d[k];
        1:       pulse = ~m_stable[k] & m_stable_d[k];
        default: pulse = m_stable[k] ^ m_stable_d[k];
      endcase
      clr = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
      m_edgecap[k] = (m_edgecap[k] & ~clr) | pulse;
      if (wr && address == 2'd2) m_mask[k] = writedata[3:0];
      if (dbc_of(k) == 0) begin
        nst = m_hist[k][1];
      end else begin
        for (int b = 0; b < 4; b++) begin
          flip = 1'b1;
          for (int j = 1; j <= dbc_of(k); j++)
            if (m_hist[k][j][b] == m_stable[k][b]) flip = 1'b0;
          nst[b] = m_stable[k][b] ^ flip;
        end
      end
      m_stable_d[k] = m_stable[k];
      m_stable[k]   = nst;
      for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = in_port;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    bus_write(2'd2, 32'hF);
    repeat (14) tick();
    checks++;
    if (irq_v[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_irq: got %b want 1", irq_v[0]); end
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (rd_v[k] !== 32'd0 || irq_v[k] !== 1'b0) begin
        errors++; $display("FAIL reset_async dut%0d: readdata %h irq %b want 0 0", k, rd_v[k], irq_v[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0; address = 2'd0;
    repeat (3) tick();
    checks++;
    if (rd_v[0] !== 32'd0) begin errors++; $display("FAIL reset_data_early: got %h want 0", rd_v[0]); end
    tick();
    checks++;
    if (rd_v[0] !== 32'hF) begin errors++; $display("FAIL reset_data_late: got %h want f", rd_v[0]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[0] !== 32'hF || rd_v[3] !== 32'hF || rd_v[2] !== 32'h0) begin
      errors++; $display("FAIL reset_edgecap: got %h/%h/%h want f/f/0", rd_v[0], rd_v[3], rd_v[2]);
    end
  endtask

  task automatic test_rising();
    in_port = 4'h0;
    repeat (14) tick();
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h2);
    in_port = 4'h2;
    repeat (3) tick();
    checks++;
    if (irq_v[0] !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b want 0", irq_v[0]); end
    tick();
    checks++;
    if (irq_v[0] !== 1'b1) begin errors++; $display("FAIL rise_irq_clk4: got %b want 1", irq_v[0]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[0] !== 32'h2) begin errors++; $display("FAIL rise_edgecap: got %h want 2", rd_v[0]); end
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq_v[0] !== 1'b0) begin errors++; $display("FAIL rise_w1c_irq: got %b want 0", irq_v[0]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[0] !== 32'h0) begin errors++; $display("FAIL rise_w1c_edgecap: got %h want 0", rd_v[0]); end
  endtask

  task automatic test_set_wins();
    bus_write(2'd2, 32'h1);
    in_port = 4'h3;
    repeat (5) tick();
    checks++;
    if (irq_v[0] !== 1'b1) begin errors++; $display("FAIL setwin_first: got %b want 1", irq_v[0]); end
    in_port = 4'h2;
    repeat (5) tick();
    in_port = 4'h3;
    repeat (3) tick();
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq_v[0] !== 1'b1) begin errors++; $display("FAIL setwin_irq: got %b want 1", irq_v[0]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[0][0] !== 1'b1) begin errors++; $display("FAIL setwin_edgecap: got %b want 1", rd_v[0][0]); end
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[0][0] !== 1'b0 || irq_v[0] !== 1'b0) begin
      errors++; $display("FAIL setwin_clear: edgecap0 %b irq %b want 0 0", rd_v[0][0], irq_v[0]);
    end
  endtask

  task automatic test_debounce();
    in_port = 4'h0;
    repeat (14) tick();
    bus_write(2'd3, 32'hF);
    in_port = 4'h8;
    repeat (5) tick();
    in_port = 4'h0;
    repeat (15) tick();
    address = 2'd0;
    tick();
    checks++;
    if (rd_v[1] !== 32'h0) begin errors++; $display("FAIL deb_glitch_data: got %h want 0", rd_v[1]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[1] !== 32'h0 || rd_v[0] !== 32'h8) begin
      errors++; $display("FAIL deb_glitch_edgecap: got %h/%h want 0/8", rd_v[1], rd_v[0]);
    end
    in_port = 4'h8; address = 2'd0;
    repeat (10) tick();
    checks++;
    if (rd_v[1][3] !== 1'b0) begin errors++; $display("FAIL deb_data_early: got %b want 0", rd_v[1][3]); end
    tick();
    checks++;
    if (rd_v[1][3] !== 1'b1) begin errors++; $display("FAIL deb_data_late: got %b want 1", rd_v[1][3]); end
    repeat (9) tick();
    in_port = 4'h0; address = 2'd3;
    tick();
    checks++;
    if (rd_v[1][3] !== 1'b1) begin errors++; $display("FAIL deb_edgecap: got %b want 1", rd_v[1][3]); end
  endtask

  task automatic test_edge_types();
    in_port = 4'h0;
    repeat (14) tick();
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hF);
    in_port = 4'h2;
    repeat (6) tick();
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[2] !== 32'h0 || rd_v[3] !== 32'h2 || rd_v[0] !== 32'h2 || irq_v !== 4'h0) begin
      errors++; $display("FAIL edge_rise: fall %h any %h rise %h irq %h want 0 2 2 0", rd_v[2], rd_v[3], rd_v[0], irq_v);
    end
    bus_write(2'd3, 32'hF);
    in_port = 4'h0;
    repeat (6) tick();
    address = 2'd3;
    tick();
    checks++;
    if (rd_v[2] !== 32'h2 || rd_v[3] !== 32'h2 || rd_v[0] !== 32'h0 || irq_v !== 4'h0) begin
      errors++; $display("FAIL edge_fall: fall %h any %h rise %h irq %h want 2 2 0 0", rd_v[2], rd_v[3], rd_v[0], irq_v);
    end
  endtask

  task automatic test_bus();
    in_port = 4'h0;
    repeat (14) tick();
    bus_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    tick();
    checks++;
    if (rd_v[0] !== 32'h0000_000F) begin errors++; $display("FAIL bus_mask_width: got %h want 0000000f", rd_v[0]); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    checks++;
    if (rd_v[0] !== 32'h0) begin errors++; $display("FAIL bus_rsvd: got %h want 0", rd_v[0]); end
    address = 2'd2; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
    tick();
    write_n = 1'b1;
    tick();
    checks++;
    if (rd_v[0] !== 32'hF) begin errors++; $display("FAIL bus_no_cs: got %h want f", rd_v[0]); end
    bus_write(2'd0, 32'h5);
    address = 2'd0;
    tick();
    checks++;
    if (rd_v[0] !== 32'h0) begin errors++; $display("FAIL bus_data_ro: got %h want 0", rd_v[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom);
      writedata  = $urandom;
      tick();
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (rd_v[k] !== m_rd[k] || irq_v[k] !== m_irq(k)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: readdata %h irq %b want %h %b", k, n, rd_v[k], irq_v[k], m_rd[k], m_irq(k));
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0; in_port = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_rising();
    test_set_wins();
    test_debounce();
    test_edge_types();
    test_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
